qspi_sram_arbiter: RTL and testbench

- Shares one physical 23LC1024-style QSPI SRAM pin set (cs_n/sck/sio[3:0]) between two requesters inside hack_soc.
- Requester 0 is the display fetch engine (high priority); requester 1 is the CPU/loader VRAM port (low priority).
- Grants are held for whole transactions; CS_N-high spacing and starvation avoidance are enforced.
- Replaces the ad-hoc done_loading-driven pin mux with a proper transaction-boundary arbiter.

---
 rtl/qspi_sram_arbiter_pkg.sv | 24 ++
 rtl/qspi_sram_arbiter_if.sv | 22 ++
 rtl/qspi_sram_arbiter_pin_mux.sv | 56 +++++
 rtl/qspi_sram_arbiter.sv | 125 ++++++++++++
 tb/tb_qspi_sram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_sram_arbiter_pkg.sv
// Shared constants for the QSPI SRAM arbiter: state encoding, default
// SIO width, bus idle pin levels and a small saturating-increment helper.
package qspi_arb_pkg;

  localparam int SIO_WIDTH_DEF = 4;

  // FSM state encoding. The grant states double as the pin-mux select:
  // S_GRANT0 routes master 0, S_GRANT1 routes master 1, anything else idles.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT0 = 2'd1;
  localparam logic [1:0] S_GRANT1 = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  // Pin levels presented to the SRAM whenever nobody owns the bus.
  localparam logic IDLE_CS_N = 1'b1;
  localparam logic IDLE_SCK  = 1'b0;
  localparam logic IDLE_OE   = 1'b0;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/qspi_sram_arbiter_if.sv
// One requester's view of the shared QSPI pins: request/grant handshake,
// the pins it wants to drive, and the SIO input data routed back to it.
interface qspi_arb_if
  import qspi_arb_pkg::*;
#(
  parameter int SIO_WIDTH = SIO_WIDTH_DEF
);

  logic                 req;
  logic                 gnt;
  logic                 cs_n;
  logic                 sck;
  logic                 sio_oe;
  logic [SIO_WIDTH-1:0] sio_o;
  logic [SIO_WIDTH-1:0] sio_i;

  // Requester side.
  modport master (output req, cs_n, sck, sio_oe, sio_o, input gnt, sio_i);
  // Arbiter side.
  modport slave  (input req, cs_n, sck, sio_oe, sio_o, output gnt, sio_i);

endinterface

// File: rtl/qspi_sram_arbiter_pin_mux.sv
// Purely combinational 2:1 QSPI pin selector. The select is the arbiter's
// state: a grant state connects that master to the pads, every other value
// parks the pads at idle levels and returns zero SIO data to both masters.
module qspi_pin_mux
  import qspi_arb_pkg::*;
#(
  parameter int SIO_WIDTH = SIO_WIDTH_DEF
) (
  input  logic [1:0]           i_sel,
  input  logic                 i_m0_cs_n,
  input  logic                 i_m0_sck,
  input  logic                 i_m0_sio_oe,
  input  logic [SIO_WIDTH-1:0] i_m0_sio_o,
  input  logic                 i_m1_cs_n,
  input  logic                 i_m1_sck,
  input  logic                 i_m1_sio_oe,
  input  logic [SIO_WIDTH-1:0] i_m1_sio_o,
  input  logic [SIO_WIDTH-1:0] i_mem_sio_i,
  output logic                 o_mem_cs_n,
  output logic                 o_mem_sck,
  output logic                 o_mem_sio_oe,
  output logic [SIO_WIDTH-1:0] o_mem_sio_o,
  output logic [SIO_WIDTH-1:0] o_m0_sio_i,
  output logic [SIO_WIDTH-1:0] o_m1_sio_i
);

  // Route the owning master to the pads, or hold the pads idle.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    o_mem_cs_n   = IDLE_CS_N;
    o_mem_sck    = IDLE_SCK;
    o_mem_sio_oe = IDLE_OE;
    o_mem_sio_o  = '0;
    o_m0_sio_i   = '0;
    o_m1_sio_i   = '0;
    case (i_sel)
      S_GRANT0: begin
        o_mem_cs_n   = i_m0_cs_n;
        o_mem_sck    = i_m0_sck;
        o_mem_sio_oe = i_m0_sio_oe;
        o_mem_sio_o  = i_m0_sio_o;
        o_m0_sio_i   = i_mem_sio_i;
      end
      S_GRANT1: begin
        o_mem_cs_n   = i_m1_cs_n;
        o_mem_sck    = i_m1_sck;
        o_mem_sio_oe = i_m1_sio_oe;
        o_mem_sio_o  = i_m1_sio_o;
        o_m1_sio_i   = i_mem_sio_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/qspi_sram_arbiter.sv
// Transaction-level arbiter sharing one QSPI SRAM between the display fetch
// engine (m0, high priority) and the CPU/loader VRAM port (m1). A grant is
// held until its master has dropped req with cs_n high, then the bus is
// parked idle for CS_GAP_CYCLES before the next arbitration. m1 is forced
// through after STARVE_LIMIT consecutive m0 wins while it was waiting.
module qspi_sram_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int SIO_WIDTH     = SIO_WIDTH_DEF,
  parameter int CS_GAP_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  qspi_arb_if.slave            m0,
  qspi_arb_if.slave            m1,
  output logic                 o_mem_cs_n,
  output logic                 o_mem_sck,
  output logic                 o_mem_sio_oe,
  output logic [SIO_WIDTH-1:0] o_mem_sio_o,
  input  logic [SIO_WIDTH-1:0] i_mem_sio_i,
  output logic                 o_busy
);

  localparam logic [3:0] GAP_LOAD   = 4'(CS_GAP_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0] r_state;
  logic [3:0] r_gap_cnt;
  logic [3:0] r_starve_cnt;

  logic [1:0] w_state_nxt;
  logic [3:0] w_gap_nxt;
  logic [3:0] w_starve_nxt;

  // Next-state, gap countdown and starvation bookkeeping.
  always_comb begin
    w_state_nxt  = r_state;
    w_gap_nxt    = r_gap_cnt;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      S_IDLE: begin
        if (m0.req && m1.req) begin
          if (r_starve_cnt == STARVE_MAX) begin
            w_state_nxt  = S_GRANT1;
            w_starve_nxt = '0;
          end else begin
            w_state_nxt  = S_GRANT0;
            w_starve_nxt = sat_inc(r_starve_cnt, STARVE_MAX);
          end
        end else if (m0.req) begin
          // m1 is not waiting, so this win does not count toward starvation.
          w_state_nxt = S_GRANT0;
        end else if (m1.req) begin
          w_state_nxt  = S_GRANT1;
          w_starve_nxt = '0;
        end
      end
      S_GRANT0: begin
        // Only release on a closed CS so the SRAM never sees a cut frame.
        if (!m0.req && m0.cs_n) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      S_GRANT1: begin
        if (!m1.req && m1.cs_n) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state      <= S_IDLE;
      r_gap_cnt    <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Grants are straight decodes of the state register, so they change only
  // on clock edges.
  assign m0.gnt = (r_state == S_GRANT0);
  assign m1.gnt = (r_state == S_GRANT1);
  assign o_busy = (r_state != S_IDLE);

  qspi_pin_mux #(
    .SIO_WIDTH(SIO_WIDTH)
  ) u_pin_mux (
    .i_sel        (r_state),
    .i_m0_cs_n    (m0.cs_n),
    .i_m0_sck     (m0.sck),
    .i_m0_sio_oe  (m0.sio_oe),
    .i_m0_sio_o   (m0.sio_o),
    .i_m1_cs_n    (m1.cs_n),
    .i_m1_sck     (m1.sck),
    .i_m1_sio_oe  (m1.sio_oe),
    .i_m1_sio_o   (m1.sio_o),
    .i_mem_sio_i  (i_mem_sio_i),
    .o_mem_cs_n   (o_mem_cs_n),
    .o_mem_sck    (o_mem_sck),
    .o_mem_sio_oe (o_mem_sio_oe),
    .o_mem_sio_o  (o_mem_sio_o),
    .o_m0_sio_i   (m0.sio_i),
    .o_m1_sio_i   (m1.sio_i)
  );

endmodule

// File: tb/tb_qspi_sram_arbiter.sv
// Bench for qspi_sram_arbiter: directed scenarios plus a randomized phase
// checked against a bus-ownership model (owner, gap cycles left, starvation
// tally) kept here in plain integers.
module tb_qspi_sram_arbiter;

  localparam int W   = 4;
  localparam int GAP = 2;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qspi_arb_if #(.SIO_WIDTH(W)) m0_if ();
  qspi_arb_if #(.SIO_WIDTH(W)) m1_if ();

  logic         mem_cs_n;
  logic         mem_sck;
  logic         mem_sio_oe;
  logic [W-1:0] mem_sio_o;
  logic [W-1:0] mem_sio_i;
  logic         busy;

  qspi_sram_arbiter #(
    .SIO_WIDTH    (W),
    .CS_GAP_CYCLES(GAP),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .o_mem_cs_n  (mem_cs_n),
    .o_mem_sck   (mem_sck),
    .o_mem_sio_oe(mem_sio_oe),
    .o_mem_sio_o (mem_sio_o),
    .i_mem_sio_i (mem_sio_i),
    .o_busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus (-1 nobody), forced-idle cycles still
  // to run, and how many m0 wins m1 has sat through.
  int own      = -1;
  int gap_left = 0;
  int starve   = 0;

  task automatic model_update();
    if (reset) begin
      own = -1; gap_left = 0; starve = 0;
    end else if (own == 0) begin
      if (!m0_if.req && m0_if.cs_n) begin own = -1; gap_left = GAP; end
    end else if (own == 1) begin
      if (!m1_if.req && m1_if.cs_n) begin own = -1; gap_left = GAP; end
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (m0_if.req && m1_if.req) begin
      if (starve == LIM) begin own = 1; starve = 0; end
      else begin own = 0; starve = (starve < LIM) ? starve + 1 : LIM; end
    end else if (m0_if.req) begin
      own = 0;
    end else if (m1_if.req) begin
      own = 1; starve = 0;
    end
  endtask

  // Advance one clock: inputs were set at the falling edge, the model takes
  // the rising edge together with the DUT, outputs are read at the next fall.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_masters();
    m0_if.req = 0; m0_if.cs_n = 1; m0_if.sck = 0; m0_if.sio_oe = 0; m0_if.sio_o = '0;
    m1_if.req = 0; m1_if.cs_n = 1; m1_if.sck = 0; m1_if.sio_oe = 0; m1_if.sio_o = '0;
    mem_sio_i = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    // Masters drive activity that must be ignored while nobody is granted.
    m0_if.cs_n = 0; m0_if.sck = 1; m0_if.sio_oe = 1; m0_if.sio_o = 4'hF;
    m1_if.cs_n = 0; m1_if.sck = 1; m1_if.sio_oe = 1; m1_if.sio_o = 4'hF;
    mem_sio_i = 4'hF;
    step(); step();
    total++;
    if ({m0_if.gnt, m1_if.gnt, busy, mem_cs_n, mem_sck, mem_sio_oe, mem_sio_o,
         m0_if.sio_i, m1_if.sio_i} !== {3'b000, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0}) begin
      bad++;
      $display("FAIL reset_state: got g0=%b g1=%b busy=%b cs_n=%b sck=%b oe=%b o=%h i0=%h i1=%h, want 0 0 0 1 0 0 0 0 0",
               m0_if.gnt, m1_if.gnt, busy, mem_cs_n, mem_sck, mem_sio_oe, mem_sio_o,
               m0_if.sio_i, m1_if.sio_i);
    end
    reset = 0;
    idle_masters();
    step();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || m0_if.gnt || m1_if.gnt) && n < 30) begin step(); n++; end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic test_single_m1();
    m1_if.req = 1;
    total++;
    if (m1_if.gnt !== 1'b0) begin bad++; $display("FAIL m1_gnt_early: got %b want 0", m1_if.gnt); end
    step();
    total++;
    if ({m0_if.gnt, m1_if.gnt, busy} !== 3'b011) begin
      bad++; $display("FAIL m1_grant_latency: got g0g1busy=%b want 011", {m0_if.gnt, m1_if.gnt, busy});
    end
    // m0 wiggles its pins without owning the bus; they must not leak through.
    m0_if.cs_n = 0; m0_if.sio_o = 4'h3; m0_if.sck = 1;
    m1_if.cs_n = 0; m1_if.sio_oe = 1; m1_if.sio_o = 4'hA; mem_sio_i = 4'h5;
    for (int k = 0; k < 4; k++) begin
      m1_if.sck = k[0];
      #1;
      total++;
      if ({mem_cs_n, mem_sck, mem_sio_oe, mem_sio_o, m1_if.sio_i, m0_if.sio_i} !==
          {1'b0, k[0], 1'b1, 4'hA, 4'h5, 4'h0}) begin
        bad++;
        $display("FAIL m1_routing: got cs_n=%b sck=%b oe=%b o=%h i1=%h i0=%h want 0 %b 1 a 5 0",
                 mem_cs_n, mem_sck, mem_sio_oe, mem_sio_o, m1_if.sio_i, m0_if.sio_i, k[0]);
      end
      step();
    end
    m1_if.cs_n = 1; m1_if.req = 0; m1_if.sck = 0;
    step();
    total++;
    if ({m1_if.gnt, busy, mem_cs_n} !== 3'b011) begin
      bad++; $display("FAIL m1_release: got gnt/busy/cs_n=%b want 011", {m1_if.gnt, busy, mem_cs_n});
    end
    idle_masters();
    wait_idle("single_m1");
  endtask

  task automatic test_simultaneous();
    int gap_seen = 0, idle_seen = 0, n = 0;
    m0_if.req = 1; m1_if.req = 1;
    step();
    total++;
    if ({m0_if.gnt, m1_if.gnt} !== 2'b10) begin
      bad++; $display("FAIL tie_priority: got g0g1=%b want 10", {m0_if.gnt, m1_if.gnt});
    end
    m0_if.cs_n = 0;
    step();
    m0_if.cs_n = 1; m0_if.req = 0;
    step();
    while (!m1_if.gnt && n < 20) begin
      if (mem_cs_n !== 1'b1) begin
        total++; bad++; $display("FAIL gap_cs_n: got %b want 1", mem_cs_n);
      end
      if (busy) gap_seen++; else idle_seen++;
      step(); n++;
    end
    total++;
    if (gap_seen != GAP || idle_seen != 1 || m1_if.gnt !== 1'b1) begin
      bad++;
      $display("FAIL gap_then_m1: got gap=%0d idle=%0d g1=%b want gap=%0d idle=1 g1=1",
               gap_seen, idle_seen, m1_if.gnt, GAP);
    end
    m1_if.req = 0;
    step();
    wait_idle("simultaneous");
  endtask

  task automatic test_starvation();
    int order[$];
    int tcnt[2] = '{0, 0};
    bit want1 = 1;
    bit pg0 = 0, pg1 = 0;
    int n = 0;
    int exp_order[6] = '{0, 0, 0, 0, 1, 0};
    while (order.size() < 6 && n < 300) begin
      if (m0_if.gnt && !pg0) order.push_back(0);
      if (m1_if.gnt && !pg1) begin order.push_back(1); want1 = 0; end
      pg0 = m0_if.gnt; pg1 = m1_if.gnt;
      if (m0_if.gnt) begin
        if (tcnt[0] < 2) begin m0_if.cs_n = 0; m0_if.req = 1; tcnt[0]++; end
        else begin m0_if.cs_n = 1; m0_if.req = 0; end
      end else begin tcnt[0] = 0; m0_if.cs_n = 1; m0_if.req = 1; end
      if (m1_if.gnt) begin
        if (tcnt[1] < 2) begin m1_if.cs_n = 0; m1_if.req = 1; tcnt[1]++; end
        else begin m1_if.cs_n = 1; m1_if.req = 0; end
      end else begin tcnt[1] = 0; m1_if.cs_n = 1; m1_if.req = want1; end
      step(); n++;
    end
    total++;
    if (order.size() != 6) begin
      bad++; $display("FAIL starve_order_len: got %0d grants want 6", order.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (order[k] != exp_order[k]) begin
          bad++; $display("FAIL starve_order[%0d]: got m%0d want m%0d", k, order[k], exp_order[k]);
        end
      end
    end
    idle_masters();
    step();
    wait_idle("starvation");
  endtask

  task automatic test_req_drop_cs_low();
    m1_if.req = 1;
    step();
    m1_if.cs_n = 0; m1_if.sio_oe = 1; m1_if.sio_o = 4'h6;
    step();
    m1_if.req = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({m1_if.gnt, mem_cs_n, mem_sio_o} !== {1'b1, 1'b0, 4'h6}) begin
        bad++; $display("FAIL drop_hold[%0d]: got g1=%b cs_n=%b o=%h want 1 0 6",
                        k, m1_if.gnt, mem_cs_n, mem_sio_o);
      end
    end
    m1_if.cs_n = 1;
    step();
    total++;
    if ({m1_if.gnt, busy, mem_cs_n, mem_sio_o} !== {1'b0, 1'b1, 1'b1, 4'h0}) begin
      bad++; $display("FAIL drop_release: got g1=%b busy=%b cs_n=%b o=%h want 0 1 1 0",
                      m1_if.gnt, busy, mem_cs_n, mem_sio_o);
    end
    idle_masters();
    wait_idle("req_drop");
  endtask

  task automatic test_reset_mid();
    m0_if.req = 1;
    step();
    m0_if.cs_n = 0; m0_if.sck = 1; m0_if.sio_oe = 1; m0_if.sio_o = 4'hF;
    step();
    total++;
    if ({m0_if.gnt, mem_cs_n} !== 2'b10) begin
      bad++; $display("FAIL mid_setup: got g0=%b cs_n=%b want 1 0", m0_if.gnt, mem_cs_n);
    end
    reset = 1;
    step();
    total++;
    if ({mem_cs_n, m0_if.gnt, m1_if.gnt, busy, mem_sck, mem_sio_oe} !== 6'b100000) begin
      bad++; $display("FAIL mid_reset: got cs_n=%b g0=%b g1=%b busy=%b sck=%b oe=%b want 1 0 0 0 0 0",
                      mem_cs_n, m0_if.gnt, m1_if.gnt, busy, mem_sck, mem_sio_oe);
    end
    reset = 0;
    idle_masters();
    step();
    test_single_m1();
  endtask

  task automatic test_random();
    logic [W-1:0] e_o, e_i0, e_i1;
    logic e_cs, e_sck, e_oe;
    reset = 1; idle_masters();
    step();
    reset = 0;
    for (int c = 0; c < 600; c++) begin
      e_cs  = (own == 0) ? m0_if.cs_n   : (own == 1) ? m1_if.cs_n   : 1'b1;
      e_sck = (own == 0) ? m0_if.sck    : (own == 1) ? m1_if.sck    : 1'b0;
      e_oe  = (own == 0) ? m0_if.sio_oe : (own == 1) ? m1_if.sio_oe : 1'b0;
      e_o   = (own == 0) ? m0_if.sio_o  : (own == 1) ? m1_if.sio_o  : '0;
      e_i0  = (own == 0) ? mem_sio_i : '0;
      e_i1  = (own == 1) ? mem_sio_i : '0;
      total++;
      if ({m0_if.gnt, m1_if.gnt, busy, mem_cs_n, mem_sck, mem_sio_oe, mem_sio_o, m0_if.sio_i, m1_if.sio_i} !==
          {own == 0, own == 1, (own >= 0) || (gap_left > 0), e_cs, e_sck, e_oe, e_o, e_i0, e_i1}) begin
        bad++;
        $display("FAIL random[%0d]: got g0=%b g1=%b busy=%b cs_n=%b sck=%b oe=%b o=%h i0=%h i1=%h want g0=%b g1=%b busy=%b cs_n=%b sck=%b oe=%b o=%h i0=%h i1=%h",
                 c, m0_if.gnt, m1_if.gnt, busy, mem_cs_n, mem_sck, mem_sio_oe, mem_sio_o, m0_if.sio_i, m1_if.sio_i,
                 own == 0, own == 1, (own >= 0) || (gap_left > 0), e_cs, e_sck, e_oe, e_o, e_i0, e_i1);
      end
      reset        = ($urandom_range(0, 59) == 0);
      m0_if.req    = ($urandom_range(0, 9) < 6);
      m1_if.req    = ($urandom_range(0, 9) < 6);
      m0_if.cs_n   = $urandom_range(0, 1);
      m1_if.cs_n   = $urandom_range(0, 1);
      m0_if.sck    = $urandom_range(0, 1);
      m1_if.sck    = $urandom_range(0, 1);
      m0_if.sio_oe = $urandom_range(0, 1);
      m1_if.sio_oe = $urandom_range(0, 1);
      m0_if.sio_o  = W'($urandom);
      m1_if.sio_o  = W'($urandom);
      mem_sio_i    = W'($urandom);
      step();
    end
    reset = 0;
    idle_masters();
  endtask

  initial begin
    reset = 1;
    idle_masters();
    @(negedge clk);
    test_reset();
    test_single_m1();
    test_simultaneous();
    test_starvation();
    test_req_drop_cs_low();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
